mcp3202_conv_sched: RTL and testbench
=====================================

MCP3202_CONV_SCHED -- requirements
Module: mcp3202_conv_sched

Interface
REQ-001 Parameter FCLK, default 100e6: system clock frequency in Hz.
REQ-002 Parameter FSMPL, default 200: per-channel sampling frequency in Hz.
REQ-003 Parameter SMPLS, default 30: samples per output packet.
REQ-004 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port enable, input, 1: run gate; 0 means stop scheduling new conversions.
REQ-007 Port ch_en, input, 2: channel enable mask; bit0 selects CH0, bit1 selects CH1.
REQ-008 Port conv_start, output, 1: one-cycle start pulse to the SPI master.
REQ-009 Port conv_sgl, output, 1: SGL bit for the conversion; always 1 (single-ended).
REQ-010 Port conv_odd, output, 1: ODD bit (channel) for the conversion; held stable from conv_start until conv_done.
REQ-011 Port conv_done, input, 1: one-cycle pulse from the SPI master, result valid.
REQ-012 Port conv_data, input, 12: ADC result, sampled on conv_done.
REQ-013 Port m_axis_tdata, output, 16: {channel, 3'b000, result[11:0]}.
REQ-014 Ports m_axis_tvalid (out, 1), m_axis_tready (in, 1), m_axis_tlast (out, 1): AXI4-Stream master.
REQ-015 Port pkt_irq, output, 1: one-cycle pulse when a tlast beat is accepted.
REQ-016 Port overrun, output, 1: sticky; a sample tick arrived while the previous round was unfinished.
REQ-017 Port overrun_clr, input, 1: synchronous clear of overrun.

Function
REQ-018 Tick counter of width clog2(FCLK/FSMPL) SHALL produce a one-cycle tick every FCLK/FSMPL clocks while enable=1, and SHALL hold at 0 while enable=0.
REQ-019 FSM states SHALL be IDLE, START, CONV, PUSH, NEXT.
REQ-020 IDLE->START on tick when ch_en!=0; first channel is the lowest enabled channel.
REQ-021 START SHALL assert conv_start for exactly one cycle with conv_odd=channel, then go to CONV.
REQ-022 CONV SHALL wait for conv_done, latch conv_data into a holding register, then go to PUSH.
REQ-023 PUSH SHALL assert m_axis_tvalid with stable tdata/tlast until tvalid&tready, then go to NEXT.
REQ-024 NEXT SHALL go to START for the next higher enabled channel in the mask, or to IDLE when none remain.
REQ-025 A round SHALL convert every enabled channel exactly once, in order CH0 then CH1.
REQ-026 Beat counter (0..SMPLS-1) SHALL increment per accepted beat; tlast=1 when count=SMPLS-1; count wraps to 0 on that beat.
REQ-027 pkt_irq SHALL pulse the cycle after the accepted tlast beat.
REQ-028 Tick while state!=IDLE SHALL set overrun and SHALL be dropped (no queued round).
REQ-029 overrun_clr and a simultaneous tick-in-busy SHALL leave overrun=1 (set wins).
REQ-030 ch_en SHALL be sampled at round start; mid-round changes SHALL take effect next round.
REQ-031 enable deassert mid-round SHALL let the current round finish; no new round SHALL start.
REQ-032 tready held low SHALL stall the FSM in PUSH indefinitely without data loss; conv_start SHALL NOT assert.
REQ-033 ch_en=0 SHALL keep the FSM in IDLE; ticks SHALL be ignored, not counted as overrun.

Reset
REQ-034 On rst_n=0, the FSM SHALL enter IDLE, and the tick and beat counters SHALL clear to 0.
REQ-035 On rst_n=0, conv_start, m_axis_tvalid, m_axis_tlast, pkt_irq and overrun SHALL be 0; conv_odd 0; m_axis_tdata 0.
REQ-036 Reset mid-conversion SHALL abandon the conversion; a late conv_done in IDLE SHALL be ignored.

Structure
REQ-037 The FSM state encoding and the tdata field layout (channel bit 15, result bits 11:0) SHALL live in shared package mcp3202_pkg.
REQ-038 The tick generator SHALL be a sub-module, smpl_tick_gen (params FCLK, FSMPL; ports clk, rst_n, en, tick).

Verification
REQ-039 FCLK=100e6, FSMPL=1e6, ch_en=01, tready=1, SPI model returns 0xABC -> one beat per 100 clocks, tdata=0x0ABC, conv_odd=0.
REQ-040 ch_en=11, returns CH0=0x111, CH1=0x222 -> beats 0x0111 then 0x8222 per tick, in that order.
REQ-041 SMPLS=30, ch_en=01 -> tlast and pkt_irq on beats 30, 60; beat counter wraps.
REQ-042 tready=0 for 250 clocks at FSMPL=1e6 -> overrun=1, tdata held stable, no conv_start; after overrun_clr, overrun=0.
REQ-043 rst_n low during CONV, conv_done pulsed after release -> no beat, all outputs per REQ-035.
REQ-044 ch_en changed 01->10 mid-round -> current round emits CH0 only; next round emits CH1 only.

Source files
------------

// File: rtl/mcp3202_pkg.sv
// Shared definitions for the MCP3202 conversion scheduler: FSM encoding and
// the AXI-Stream beat layout.
package mcp3202_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_PUSH  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    localparam int RES_W = 12;

    // Channel in bit 15, result in bits 11:0, bits 14:12 reserved as zero.
    typedef struct packed {
        logic             ch;
        logic [2:0]       rsvd;
        logic [RES_W-1:0] res;
    } beat_t;

    function automatic beat_t pack_beat(input logic ch, input logic [RES_W-1:0] res);
        beat_t b;
        b.ch   = ch;
        b.rsvd = '0;
        b.res  = res;
        return b;
    endfunction

endpackage

// File: rtl/smpl_tick_gen.sv
// Sample-rate tick: one-cycle pulse every FCLK/FSMPL clocks while en is high.
module smpl_tick_gen #(
    parameter int unsigned FCLK  = 100_000_000,
    parameter int unsigned FSMPL = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned DIV = FCLK / FSMPL;
    localparam int          W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TOP = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Counter parks at zero while disabled so re-enabling gives a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == TOP);
            cnt  <= (cnt == TOP) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/mcp3202_conv_sched.sv
// MCP3202 conversion scheduler: per tick, converts each enabled channel once
// (CH0 then CH1) and streams the results out in SMPLS-beat packets.
module mcp3202_conv_sched
    import mcp3202_pkg::*;
#(
    parameter int unsigned FCLK  = 100_000_000,
    parameter int unsigned FSMPL = 200,
    parameter int unsigned SMPLS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  ch_en,
    output logic        conv_start,
    output logic        conv_sgl,
    output logic        conv_odd,
    input  logic        conv_done,
    input  logic [11:0] conv_data,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        pkt_irq,
    output logic        overrun,
    input  logic        overrun_clr
);

    localparam int            BW   = (SMPLS > 1) ? $clog2(SMPLS) : 1;
    localparam logic [BW-1:0] LAST = BW'(SMPLS - 1);

    logic [2:0]    state;
    logic          tick;
    logic          ch;
    logic          hi_en;
    logic [BW-1:0] beat_cnt;
    beat_t         hold;
    logic          accept;

    smpl_tick_gen #(
        .FCLK  (FCLK),
        .FSMPL (FSMPL)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .tick  (tick)
    );

    assign conv_start    = (state == S_START);
    assign conv_sgl      = 1'b1;
    assign conv_odd      = ch;
    assign m_axis_tvalid = (state == S_PUSH);
    assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == LAST);
    assign m_axis_tdata  = hold;
    assign accept        = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ch       <= 1'b0;
            hi_en    <= 1'b0;
            hold     <= '0;
            beat_cnt <= '0;
            pkt_irq  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            pkt_irq <= accept && m_axis_tlast;

            // A tick landing on a busy round is dropped; setting beats clearing.
            if (tick && state != S_IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    // Mask is captured here so mid-round edits wait for the next round.
                    if (tick && ch_en != 2'b00) begin
                        ch    <= ~ch_en[0];
                        hi_en <= ch_en[1];
                        state <= S_START;
                    end
                end
                S_START: state <= S_CONV;
                S_CONV: begin
                    if (conv_done) begin
                        hold  <= pack_beat(ch, conv_data);
                        state <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (m_axis_tready) begin
                        beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + BW'(1);
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (!ch && hi_en) begin
                        ch    <= 1'b1;
                        state <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcp3202_conv_sched.sv
// Directed bench for mcp3202_conv_sched with a behavioural SPI responder.
module tb_mcp3202_conv_sched;

    logic        clk, rst_n, enable;
    logic [1:0]  ch_en;
    logic        conv_start, conv_sgl, conv_odd, conv_done;
    logic [11:0] conv_data;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic        pkt_irq, overrun, overrun_clr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [11:0] ret0 = 12'hABC, ret1 = 12'h000;
    int          spi_lat = 5;

    int          n_start = 0;
    logic        odd_q[$];
    logic [15:0] beat_q[$];
    logic        last_q[$];
    int          bcyc_q[$];
    int          irq_q[$];

    mcp3202_conv_sched #(
        .FCLK  (100_000_000),
        .FSMPL (1_000_000),
        .SMPLS (30)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .ch_en         (ch_en),
        .conv_start    (conv_start),
        .conv_sgl      (conv_sgl),
        .conv_odd      (conv_odd),
        .conv_done     (conv_done),
        .conv_data     (conv_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_irq       (pkt_irq),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: everything sampled on the falling edge.
    always @(negedge clk) begin
        if (conv_start) begin
            n_start++;
            odd_q.push_back(conv_odd);
        end
        if (m_axis_tvalid && m_axis_tready) begin
            beat_q.push_back(m_axis_tdata);
            last_q.push_back(m_axis_tlast);
            bcyc_q.push_back(cyc);
        end
        if (pkt_irq) irq_q.push_back(cyc);
    end

    // SPI responder: answers each conv_start after spi_lat clocks.
    initial begin
        logic odd_s;
        conv_done = 1'b0;
        conv_data = '0;
        forever begin
            @(negedge clk);
            if (conv_start) begin
                odd_s = conv_odd;
                repeat (spi_lat) @(posedge clk);
                #1;
                conv_data = odd_s ? ret1 : ret0;
                conv_done = 1'b1;
                @(posedge clk);
                #1;
                conv_done = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_start = 0;
        odd_q.delete();
        beat_q.delete();
        last_q.delete();
        bcyc_q.delete();
        irq_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        m_axis_tready = 1'b1;
        overrun_clr = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        clear_mon();
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (beat_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        step(1);
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_start >= n) begin
                ok = 1'b1;
                break;
            end
        end
        step(1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        ch_en = 2'b01;
        m_axis_tready = 1'b1;
        overrun_clr = 1'b0;
        step(2);
        checks++; if (conv_start !== 1'b0) begin errors++; $display("FAIL reset_conv_start got=%b exp=0", conv_start); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
        checks++; if (pkt_irq !== 1'b0) begin errors++; $display("FAIL reset_pkt_irq got=%b exp=0", pkt_irq); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (conv_odd !== 1'b0) begin errors++; $display("FAIL reset_conv_odd got=%b exp=0", conv_odd); end
        checks++; if (m_axis_tdata !== 16'h0000) begin errors++; $display("FAIL reset_tdata got=%h exp=0000", m_axis_tdata); end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        ch_en = 2'b01;
        ret0 = 12'hABC;
        enable = 1'b1;
        wait_beats(3, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=%0d beats exp=3", beat_q.size()); end
        if (ok) begin
            checks++; if (beat_q[0] !== 16'h0ABC) begin errors++; $display("FAIL single_beat0 got=%h exp=0abc", beat_q[0]); end
            checks++; if (beat_q[2] !== 16'h0ABC) begin errors++; $display("FAIL single_beat2 got=%h exp=0abc", beat_q[2]); end
            checks++; if (bcyc_q[2] - bcyc_q[1] !== 100) begin errors++; $display("FAIL single_period got=%0d exp=100", bcyc_q[2] - bcyc_q[1]); end
            checks++; if (odd_q[0] !== 1'b0) begin errors++; $display("FAIL single_odd got=%b exp=0", odd_q[0]); end
        end
        checks++; if (conv_sgl !== 1'b1) begin errors++; $display("FAIL single_sgl got=%b exp=1", conv_sgl); end
        enable = 1'b0;
        step(20);
    endtask

    task automatic test_two_ch();
        bit ok;
        logic [15:0] exp_b[4];
        exp_b = '{16'h0111, 16'h8222, 16'h0111, 16'h8222};
        do_reset();
        ch_en = 2'b11;
        ret0 = 12'h111;
        ret1 = 12'h222;
        enable = 1'b1;
        wait_beats(4, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL two_ch_timeout got=%0d beats exp=4", beat_q.size()); end
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (beat_q[i] !== exp_b[i]) begin errors++; $display("FAIL two_ch_beat%0d got=%h exp=%h", i, beat_q[i], exp_b[i]); end
            end
            checks++; if (odd_q[1] !== 1'b1) begin errors++; $display("FAIL two_ch_odd1 got=%b exp=1", odd_q[1]); end
        end
        enable = 1'b0;
        step(20);
    endtask

    task automatic test_tlast();
        bit ok;
        int bad;
        do_reset();
        ch_en = 2'b01;
        ret0 = 12'h5A5;
        enable = 1'b1;
        wait_beats(61, 6300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tlast_timeout got=%0d beats exp=61", beat_q.size()); end
        if (ok) begin
            bad = 0;
            for (int i = 0; i < 61; i++)
                if (last_q[i] !== ((i == 29) || (i == 59))) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL tlast_pattern got=%0d wrong beats exp=0", bad); end
            checks++; if (irq_q.size() != 2) begin errors++; $display("FAIL irq_count got=%0d exp=2", irq_q.size()); end
            if (irq_q.size() == 2) begin
                checks++; if (irq_q[0] != bcyc_q[29] + 1) begin errors++; $display("FAIL irq0_cycle got=%0d exp=%0d", irq_q[0], bcyc_q[29] + 1); end
                checks++; if (irq_q[1] != bcyc_q[59] + 1) begin errors++; $display("FAIL irq1_cycle got=%0d exp=%0d", irq_q[1], bcyc_q[59] + 1); end
            end
        end
        enable = 1'b0;
        step(20);
    endtask

    task automatic test_stall();
        bit ok, seen;
        int bad, starts0;
        logic [15:0] held;
        do_reset();
        ch_en = 2'b01;
        ret0 = 12'hABC;
        m_axis_tready = 1'b0;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_tvalid_timeout got=0 exp=1"); end
        held = m_axis_tdata;
        starts0 = n_start;
        bad = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (m_axis_tdata !== held || m_axis_tvalid !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", bad); end
        checks++; if (held !== 16'h0ABC) begin errors++; $display("FAIL stall_tdata got=%h exp=0abc", held); end
        checks++; if (n_start != starts0) begin errors++; $display("FAIL stall_starts got=%0d exp=%0d", n_start, starts0); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL stall_overrun got=%b exp=1", overrun); end
        // Hold clear through a tick: the tick must win.
        step(1);
        overrun_clr = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (dut.u_tick.tick) begin seen = 1'b1; break; end
        end
        step(1);
        checks++; if (!seen || overrun !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", overrun); end
        overrun_clr = 1'b0;
        enable = 1'b0;
        beat_q.delete();
        m_axis_tready = 1'b1;
        step(10);
        checks++; if (beat_q.size() != 1 || beat_q[0] !== 16'h0ABC) begin errors++; $display("FAIL stall_drain got=%0d beats exp=1 of 0abc", beat_q.size()); end
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        step(1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got=%b exp=0", overrun); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        ch_en = 2'b01;
        spi_lat = 20;
        enable = 1'b1;
        wait_starts(1, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_start_timeout got=0 exp=1"); end
        step(2);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0 || conv_start !== 1'b0 || m_axis_tdata !== 16'h0)
            begin errors++; $display("FAIL rstmid_outputs got=%b%b/%h exp=00/0000", m_axis_tvalid, conv_start, m_axis_tdata); end
        step(2);
        rst_n = 1'b1;
        step(40);
        checks++; if (beat_q.size() != 0) begin errors++; $display("FAIL rstmid_beats got=%0d exp=0", beat_q.size()); end
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'h0 || overrun !== 1'b0 || conv_odd !== 1'b0)
            begin errors++; $display("FAIL rstmid_idle got=%b/%h/%b/%b exp=0/0000/0/0", m_axis_tvalid, m_axis_tdata, overrun, conv_odd); end
        spi_lat = 5;
    endtask

    task automatic test_ch_change();
        bit ok;
        do_reset();
        ch_en = 2'b01;
        ret0 = 12'h123;
        ret1 = 12'h456;
        enable = 1'b1;
        wait_starts(1, 300, ok);
        ch_en = 2'b10;
        wait_beats(2, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL chg_timeout got=%0d beats exp=2", beat_q.size()); end
        if (ok) begin
            checks++; if (beat_q[0] !== 16'h0123) begin errors++; $display("FAIL chg_round1 got=%h exp=0123", beat_q[0]); end
            checks++; if (beat_q[1] !== 16'h8456) begin errors++; $display("FAIL chg_round2 got=%h exp=8456", beat_q[1]); end
            checks++; if (bcyc_q[1] - bcyc_q[0] !== 100) begin errors++; $display("FAIL chg_spacing got=%0d exp=100", bcyc_q[1] - bcyc_q[0]); end
        end
        enable = 1'b0;
        step(20);
    endtask

    task automatic test_enable_mid();
        bit ok;
        do_reset();
        ch_en = 2'b11;
        enable = 1'b1;
        wait_starts(1, 300, ok);
        enable = 1'b0;
        step(300);
        checks++; if (beat_q.size() != 2) begin errors++; $display("FAIL en_mid_beats got=%0d exp=2", beat_q.size()); end
        checks++; if (n_start != 2) begin errors++; $display("FAIL en_mid_starts got=%0d exp=2", n_start); end
    endtask

    task automatic test_zero_mask();
        do_reset();
        ch_en = 2'b00;
        enable = 1'b1;
        step(350);
        checks++; if (n_start != 0) begin errors++; $display("FAIL zero_starts got=%0d exp=0", n_start); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL zero_overrun got=%b exp=0", overrun); end
        enable = 1'b0;
        step(5);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        ch_en = 2'b00;
        m_axis_tready = 1'b1;
        overrun_clr = 1'b0;
        test_reset();
        test_single();
        test_two_ch();
        test_tlast();
        test_stall();
        test_reset_mid();
        test_ch_change();
        test_enable_mid();
        test_zero_mask();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
